alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the team's registered 4-op ALU.
- Two-stage pipeline: stage 1 registers operands and opcode; stage 2 registers result and status.
- Eight operations, valid/ready flow control on both sides, full-throughput back-pressure, and a saturating error-event counter.
- Sits between the operand sequencer and the result FIFO in the datapath.

---
 rtl/alu_pipe_if.sv | 26 ++
 rtl/alu_pipe.sv | 161 ++++++++++++++++
 tb/tb_alu_pipe.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The environment (sequencer side and FIFO side) takes the master view,
// the ALU takes the slave view.
interface alu_pipe_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0] i_a;
  logic [BITS-1:0] i_b;
  logic [2:0]      i_op;
  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] o_out;
  logic [3:0]      o_status;
  logic            o_valid;
  logic            i_ready;

  modport master (
    output i_a, i_b, i_op, i_valid, i_ready,
    input  o_ready, o_out, o_status, o_valid
  );

  modport slave (
    input  i_a, i_b, i_op, i_valid, i_ready,
    output o_ready, o_out, o_status, o_valid
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage handshaked 8-op ALU with zero-parity status flags and a
// saturating count of delivered results that carried ERROR.
// Stage 1 holds operands/opcode, stage 2 holds result/status.
module alu_pipe #(
  parameter int BITS = 8,
  parameter int ERRW = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  alu_pipe_if.slave       bus,
  input  logic            i_clr_err,
  output logic [ERRW-1:0] o_err_cnt
);

  localparam logic [2:0] OP_SUB = 3'd0;
  localparam logic [2:0] OP_CMP = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_CHG = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  // One extra bit so the out-of-range test on b works for any BITS.
  localparam logic [BITS:0]   BITS_VAL = (BITS + 1)'(BITS);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  logic            s1_valid_reg;
  logic [BITS-1:0] s1_a_reg;
  logic [BITS-1:0] s1_b_reg;
  logic [2:0]      s1_op_reg;

  logic            out_valid_reg;
  logic [BITS-1:0] out_reg;
  logic [3:0]      status_reg;
  logic [ERRW-1:0] err_cnt_reg;

  logic            adv1;
  logic            adv2;

  logic [BITS:0]   sum_w;
  logic [BITS:0]   diff_w;
  logic [BITS-1:0] shl_w;
  logic [BITS-1:0] one_hot_w;
  logic            b_oob;

  logic [BITS-1:0] out_next;
  logic            ovf_next;
  logic            err_next;
  logic [BITS-1:0] zero_bits;
  logic            even_next;
  logic            single_next;

  // Stage 2 moves when it is empty or being drained; stage 1 moves when
  // it is empty or stage 2 moves, so a full pipe streams without bubbles.
  assign adv2 = bus.i_ready | ~out_valid_reg;
  assign adv1 = ~s1_valid_reg | adv2;

  assign bus.o_ready  = adv1;
  assign bus.o_valid  = out_valid_reg;
  assign bus.o_out    = out_reg;
  assign bus.o_status = status_reg;
  assign o_err_cnt    = err_cnt_reg;

  // Extended-width add/sub expose carry and borrow in the top bit.
  assign sum_w     = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
  assign diff_w    = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
  assign shl_w     = s1_a_reg << s1_b_reg;
  assign one_hot_w = {{(BITS-1){1'b0}}, 1'b1} << s1_b_reg;
  assign b_oob     = ({1'b0, s1_b_reg} >= BITS_VAL);

  // Result and OVF/ERROR for the opcode held in stage 1.
  always_comb begin
    out_next = '0;
    ovf_next = 1'b0;
    err_next = 1'b0;
    case (s1_op_reg)
      OP_SUB: begin
        out_next = diff_w[BITS-1:0];
        ovf_next = diff_w[BITS];
      end
      OP_CMP: out_next = {{(BITS-1){1'b0}}, (s1_a_reg > s1_b_reg)};
      OP_SHL: begin
        if (b_oob) begin
          err_next = 1'b1;
        end else begin
          out_next = shl_w;
          // Shifting back recovers a only if nothing fell off the top.
          ovf_next = ((shl_w >> s1_b_reg) != s1_a_reg);
        end
      end
      OP_CHG: begin
        if (b_oob) begin
          err_next = 1'b1;
          out_next = s1_a_reg;
        end else begin
          out_next = s1_a_reg ^ one_hot_w;
        end
      end
      OP_ADD: begin
        out_next = sum_w[BITS-1:0];
        ovf_next = sum_w[BITS];
      end
      OP_AND:  out_next = s1_a_reg & s1_b_reg;
      OP_OR:   out_next = s1_a_reg | s1_b_reg;
      default: out_next = s1_a_reg ^ s1_b_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < BITS; gi++) begin : g_zero
      assign zero_bits[gi] = ~out_next[gi];
    end
  endgenerate

  // Even zero count is even parity of the zero mask; exactly one zero is
  // a nonzero power-of-two mask. The two cannot both hold.
  assign even_next   = ~(^zero_bits);
  assign single_next = (zero_bits != '0) && ((zero_bits & (zero_bits - 1'b1)) == '0);

  // Stage 1: capture operands whenever the stage is free to advance.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= '0;
    end else if (adv1) begin
      s1_valid_reg <= bus.i_valid;
      s1_a_reg     <= bus.i_a;
      s1_b_reg     <= bus.i_b;
      s1_op_reg    <= bus.i_op;
    end
  end

  // Stage 2: register result and status; held stable while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      status_reg    <= '0;
    end else if (adv2) begin
      out_valid_reg <= s1_valid_reg;
      out_reg       <= out_next;
      status_reg    <= {single_next, even_next, err_next, ovf_next};
    end
  end

  // Error counter: counts delivered ERROR results once, saturates, clear wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_cnt_reg <= '0;
    end else if (i_clr_err) begin
      err_cnt_reg <= '0;
    end else if (out_valid_reg && bus.i_ready && status_reg[1] && (err_cnt_reg != ERR_MAX)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: arithmetic reference model plus an
// in-order expected-result queue, checked every cycle on the falling edge.
module tb_alu_pipe;
  localparam int BITS = 8;
  localparam int ERRW = 2;
  localparam int CNT_MAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic [ERRW-1:0] err_cnt;

  alu_pipe_if #(.BITS(BITS)) bus();

  alu_pipe #(.BITS(BITS), .ERRW(ERRW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .i_clr_err (clr),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         out;
    logic [3:0] st;
    int         cyc;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    m_cnt = 0;
  bit    chk_en = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model from the opcode rules, using plain integer arithmetic.
  function automatic void model(input int a, input int b, input int op,
                                output int out, output logic [3:0] st);
    int m;
    int z;
    bit ovf;
    bit err;
    m = 1 << BITS;
    ovf = 0;
    err = 0;
    out = 0;
    case (op)
      0: begin out = (a - b + m) % m; ovf = (a < b); end
      1: out = (a > b) ? 1 : 0;
      2: if (b >= BITS) err = 1;
         else begin out = (a * (1 << b)) % m; ovf = ((a * (1 << b)) >= m); end
      3: if (b >= BITS) begin err = 1; out = a; end
         else out = a ^ (1 << b);
      4: begin out = (a + b) % m; ovf = ((a + b) >= m); end
      5: out = a & b;
      6: out = a | b;
      default: out = a ^ b;
    endcase
    z = 0;
    for (int i = 0; i < BITS; i++) if (((out >> i) & 1) == 0) z++;
    st = {(z == 1), (z % 2 == 0), err, ovf};
  endfunction

  // Compare process plus model bookkeeping for the coming rising edge.
  always @(negedge clk) begin
    bit         exp_ready;
    bit         exp_valid;
    item_t      it;
    int         o;
    logic [3:0] s;
    cyc++;
    exp_ready = (q.size() < 2) || (bus.i_ready == 1'b1);
    exp_valid = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
    if (chk_en) begin
      check("o_ready", bus.o_ready, exp_ready);
      check("o_valid", bus.o_valid, exp_valid);
      check("o_err_cnt", err_cnt, m_cnt);
      if (exp_valid) begin
        check("o_out", bus.o_out, q[0].out);
        check("o_status", bus.o_status, q[0].st);
      end
    end
    if (!rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (exp_valid && bus.i_ready) begin
        $display("xfer out=0x%02h status=%b err_cnt=%0d", bus.o_out, bus.o_status, err_cnt);
        if (q[0].st[1] && m_cnt < CNT_MAX) m_cnt++;
        void'(q.pop_front());
      end
      if (clr) m_cnt = 0;
      if (bus.i_valid && exp_ready) begin
        model(int'(bus.i_a), int'(bus.i_b), int'(bus.i_op), o, s);
        it.out = o;
        it.st  = s;
        it.cyc = cyc;
        q.push_back(it);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.o_ready;
      tick();
    end
    check("accept_timeout", acc, 1'b1);
  endtask

  task automatic send(input int a, input int b, input int op);
    bus.i_a     = a[BITS-1:0];
    bus.i_b     = b[BITS-1:0];
    bus.i_op    = op[2:0];
    bus.i_valid = 1'b1;
    wait_accept();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  int         vec_a [15] = '{'h81, 'h81, 'h0F, 'h0F, 'hFF, 'h10, 9, 3, 'hF0, 'hF0, 'hAA, 7, 1, 0, 3};
  int         vec_b [15] = '{1, 8, 9, 7, 1, 'h20, 3, 9, 'h3C, 'h0F, 'hFF, 5, 7, 0, 255};
  int         vec_op[15] = '{2, 2, 3, 3, 4, 4, 1, 1, 5, 6, 7, 0, 2, 3, 2};
  int         mo;
  logic [3:0] ms;
  int         t0;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_op    = '0;
    bus.i_ready = 1'b1;
    rst         = 1'b0;
    clr         = 1'b0;

    // Pin the model to hand-computed values.
    model(5, 7, 0, mo, ms);       check("model_sub_out", mo, 'hFE);  check("model_sub_st", ms, 4'b1001);
    model('h81, 1, 2, mo, ms);    check("model_shl1_out", mo, 'h02); check("model_shl1_st", ms, 4'b0001);
    model('h81, 8, 2, mo, ms);    check("model_shl8_out", mo, 'h00); check("model_shl8_st", ms, 4'b0110);
    model('h0F, 9, 3, mo, ms);    check("model_chg9_out", mo, 'h0F); check("model_chg9_st", ms, 4'b0110);
    model('h0F, 7, 3, mo, ms);    check("model_chg7_out", mo, 'h8F); check("model_chg7_st", ms, 4'b0000);
    model('hFF, 1, 4, mo, ms);    check("model_add_out", mo, 'h00);  check("model_add_st", ms, 4'b0101);

    // Reset and reset-state literals.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_o_valid", bus.o_valid, 1'b0);
    check("rst_o_out", bus.o_out, 8'h00);
    check("rst_o_status", bus.o_status, 4'h0);
    check("rst_err_cnt", err_cnt, 2'd0);
    check("rst_o_ready", bus.o_ready, 1'b1);
    tick();

    // Single SUB: latency two edges from the accepting edge.
    send(5, 7, 0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_early", bus.o_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", bus.o_valid, 1'b1);
    check("sub_out", bus.o_out, 8'hFE);
    check("sub_status", bus.o_status, 4'b1001);
    tick();
    repeat (3) tick();

    // Directed vectors back-to-back: one accept per cycle.
    t0 = cyc;
    for (int i = 0; i < 15; i++) send(vec_a[i], vec_b[i], vec_op[i]);
    check("throughput_cycles", cyc - t0, 15);
    bus.i_valid = 1'b0;
    repeat (5) tick();

    // Back-pressure: two accepted, third refused until i_ready rises.
    bus.i_ready = 1'b0;
    bus.i_a = 8'd1; bus.i_b = 8'd2; bus.i_op = 3'd4; bus.i_valid = 1'b1;
    @(negedge clk); check("bp_ready_1", bus.o_ready, 1'b1); tick();
    bus.i_a = 8'd9; bus.i_b = 8'd4; bus.i_op = 3'd0;
    @(negedge clk); check("bp_ready_2", bus.o_ready, 1'b1); tick();
    bus.i_a = 8'd5; bus.i_b = 8'd3; bus.i_op = 3'd7;
    @(negedge clk); check("bp_ready_low", bus.o_ready, 1'b0); tick();
    repeat (3) tick();
    check("bp_held_out", bus.o_out, 8'h03);
    bus.i_ready = 1'b1;
    wait_accept();
    bus.i_valid = 1'b0;
    repeat (5) tick();

    // Error counter saturation at 3 after five erroring deliveries.
    do_reset();
    for (int i = 0; i < 5; i++) send(i + 1, 8, 2);
    bus.i_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("err_saturated", err_cnt, 2'd3);
    tick();

    // Clear coinciding with an erroring output transfer: clear wins.
    send(1, 9, 2);
    bus.i_valid = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_wins", err_cnt, 2'd0);
    tick();

    // Reset with both stages holding valid ops.
    send(0, 8, 3);
    bus.i_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("err_one", err_cnt, 2'd1);
    tick();
    bus.i_ready = 1'b0;
    send(1, 1, 4);
    send(2, 2, 4);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    tick();
    rst = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_status", bus.o_status, 4'h0);
    check("mid_rst_err_cnt", err_cnt, 2'd0);
    check("mid_rst_ready", bus.o_ready, 1'b1);
    tick();
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
